pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter sequencer and instruction-fetch controller for the KGP-RISC datapath. Issues word fetches to instruction memory with a ready handshake. Holds each fetched instruction for the decode/execute datapath until it is accepted, then computes the next PC: sequential, PC-relative branch (23-bit sign-extended label offset), register jump, or halt. Counts retired instructions and traps on misaligned targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- imem_req  out  1  fetch request; high exactly while state is FETCH.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rdy  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instr holds an instruction awaiting acceptance.
- instr  out  32  registered instruction to decode.
- pc  out  32  address of current/pending instruction.
- instr_ready  in  1  datapath accepts instr; branch inputs sampled the same cycle.
- br_taken  in  1  control-flow change for the accepted instruction.
- br_kind  in  2  00 sequential, 01 PC-relative, 10 register jump, 11 halt.
- br_offset  in  23  signed word offset for kind 01.
- br_reg_target  in  32  byte target for kind 10.
- halted  out  1  sticky; halt executed.
- fault  out  1  sticky; misaligned target computed.
- instr_count  out  32  instructions accepted since reset.

## Operation
- States: IDLE, FETCH, ISSUE, HALT, FAULT. Reset state IDLE.
- IDLE -> FETCH unconditionally.
- FETCH: imem_req=1. On imem_rdy=1: instr <= imem_rdata, -> ISSUE. Otherwise stay; wait unbounded.
- ISSUE: instr_valid=1. instr_ready=0: hold instr, pc, state. instr_ready=1: instr_count += 1, then next-PC select:
  - br_taken=0, or br_kind=00: pc + PC_STEP.
  - br_kind=01: pc + PC_STEP + (sext32(br_offset) << 2). sext32 replicates br_offset[22] into bits 31:23; shift discards the top 2 bits.
  - br_kind=10: br_reg_target.
  - br_kind=11: pc unchanged, -> HALT.
  - For kinds 00/01/10: if target[1:0] != 0, pc <= target, -> FAULT. Else pc <= target, -> FETCH.
- HALT: halted=1. FAULT: fault=1. Both are terminal until reset; no requests; instr_valid=0; pc and instr_count frozen.
- All adds are modulo 2^32; wrap is silent. Example: 0xFFFF_FFFC + 4 = 0.
- Inputs are ignored outside their state:
  - imem_rdy outside FETCH.
  - instr_ready and br_* outside ISSUE.

## Timing
- Reset (rst=0 at an edge) forces: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fault=0, instr_count=0.
- Reset applies from any state, including mid-fetch; a pending fetch is abandoned with no handshake.
- First imem_req high is one cycle after the first edge with rst=1 (IDLE cycle).
- Fetch latency: imem_rdy sampled high at edge N gives instr_valid=1 during cycle N+1.
- Zero-wait throughput: 2 cycles per instruction (FETCH, ISSUE).
- Acceptance at edge M gives imem_req=1 with the new imem_addr during cycle M+1.
- instr_valid, imem_req, halted and fault are decoded from registered state only; no combinational input-to-output paths.
- On the accepting edge, the counter increments in the same edge as the pc update, including for halt and faulting transfers.

## Test plan
- Sequential with wrap: RESET_PC=0, rst low 2 cycles, imem_rdy=1, instr_ready=1, br_taken=0 -> imem_addr 0,4,8,… on alternate cycles; instr_count=3 after third accept. Separately, RESET_PC=0xFFFF_FFFC -> second fetch at 0x0.
- PC-relative branches:
  - pc=0x40, br_kind=01, br_offset=23'h7F_FFFE -> next imem_addr=0x3C.
  - pc=0, br_offset=23'h3F_FFFF -> 0x0100_0000.
  - pc=0, br_offset=23'h40_0000 -> 0xFF00_0004.
- Register jump: br_reg_target=0x100 -> fetch at 0x100. br_reg_target=0x102 -> fault=1, pc=0x102, imem_req stays 0, instr_count incremented.
- Backpressure and memory stall:
  - imem_rdy low 3 cycles -> imem_req/imem_addr held, instr_valid=0.
  - instr_ready low 4 cycles in ISSUE -> instr, pc, instr_count stable, no request.
- Halt: accept with br_kind=11 at pc=0x20 -> halted=1, pc=0x20, instr_valid=0 thereafter, instr_count frozen; further instr_ready pulses have no effect.
- Reset mid-operation: rst low during FETCH with imem_rdy=0 -> next cycle all outputs at reset values. rst high -> IDLE, then fetch at RESET_PC; fault/halted cleared.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// PC sequencer and instruction-fetch controller.
// Fetches a word, holds it for decode, then picks the next PC.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [1:0]  br_kind,
  input  logic [22:0] br_offset,
  input  logic [31:0] br_reg_target,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT,
    FAULT
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] cnt_q;

  logic [31:0] seq_pc;
  logic [31:0] rel_off;
  logic [31:0] tgt_d;
  logic        halt_d;
  logic        mis_d;

  // Word offset sign-extended then scaled to bytes in one concat.
  always_comb begin
    seq_pc  = pc_q + STEP;
    rel_off = {{7{br_offset[22]}}, br_offset, 2'b00};
    tgt_d   = seq_pc;
    halt_d  = 1'b0;
    if (br_taken) begin
      unique case (br_kind)
        2'b01:   tgt_d = seq_pc + rel_off;
        2'b10:   tgt_d = br_reg_target;
        2'b11:   halt_d = 1'b1;
        default: tgt_d = seq_pc;
      endcase
    end
    mis_d = tgt_d[1:0] != 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_rdy) begin
            instr_q <= imem_rdata;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            cnt_q <= cnt_q + 32'd1;
            if (halt_d) begin
              state_q <= HALT;
            end else begin
              pc_q    <= tgt_d;
              state_q <= mis_d ? FAULT : FETCH;
            end
          end
        end
        HALT:    state_q <= HALT;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = state_q == FETCH;
  assign imem_addr   = pc_q;
  assign instr_valid = state_q == ISSUE;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign halted      = state_q == HALT;
  assign fault       = state_q == FAULT;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized self-checking bench for pc_fetch_sequencer.
// A high-level PC/count model predicts every observed value.
module tb_pc_fetch_sequencer;

  logic        clk = 0;
  logic        rst = 0;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_rdy = 0;
  logic [31:0] imem_rdata = 0;
  logic        instr_valid, instr_valid2;
  logic [31:0] instr, instr2;
  logic [31:0] pc, pc2;
  logic        instr_ready = 0;
  logic        br_taken = 0;
  logic [1:0]  br_kind = 0;
  logic [22:0] br_offset = 0;
  logic [31:0] br_reg_target = 0;
  logic        halted, halted2;
  logic        fault, fault2;
  logic [31:0] instr_count, instr_count2;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_term;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .instr_ready(instr_ready), .br_taken(br_taken),
    .br_kind(br_kind), .br_offset(br_offset),
    .br_reg_target(br_reg_target),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid2), .instr(instr2), .pc(pc2),
    .instr_ready(instr_ready), .br_taken(br_taken),
    .br_kind(br_kind), .br_offset(br_offset),
    .br_reg_target(br_reg_target),
    .halted(halted2), .fault(fault2), .instr_count(instr_count2)
  );

  function automatic logic [31:0] model_target(
    input logic [31:0] cur, input logic taken, input logic [1:0] kind,
    input logic [22:0] off, input logic [31:0] regt);
    longint o;
    o = longint'(off);
    if (off[22]) o = o - (64'sd1 <<< 23);
    if (!taken || kind == 2'b00) return cur + 32'd4;
    if (kind == 2'b01) return 32'(longint'(cur) + 4 + o * 4);
    return regt;
  endfunction

  task automatic do_reset();
    rst = 0; imem_rdy = 0; instr_ready = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); @(negedge clk);
    m_pc = 32'h0; m_cnt = 0; m_term = 0;
  endtask

  task automatic exec_one(input int stall, input int hold,
    input logic taken, input logic [1:0] kind,
    input logic [22:0] off, input logic [31:0] regt);
    logic [31:0] w;
    logic [31:0] t;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_req got req=%b addr=%h v=%b want 1 %h 0",
               imem_req, imem_addr, instr_valid, m_pc);
    end
    for (int i = 0; i < stall; i++) begin
      imem_rdy = 0; imem_rdata = $urandom;
      @(posedge clk); @(negedge clk);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        fails++;
        $display("FAIL mem_stall got req=%b addr=%h v=%b want 1 %h 0",
                 imem_req, imem_addr, instr_valid, m_pc);
      end
    end
    w = $urandom;
    imem_rdy = 1; imem_rdata = w;
    @(posedge clk); @(negedge clk);
    imem_rdy = 1'($urandom); imem_rdata = $urandom;
    tests++;
    if (instr_valid !== 1'b1 || instr !== w || imem_req !== 1'b0 || pc !== m_pc) begin
      fails++;
      $display("FAIL issue got v=%b instr=%h req=%b pc=%h want 1 %h 0 %h",
               instr_valid, instr, imem_req, pc, w, m_pc);
    end
    for (int i = 0; i < hold; i++) begin
      instr_ready = 0;
      br_taken = 1'($urandom); br_kind = 2'($urandom);
      br_offset = 23'($urandom); br_reg_target = $urandom;
      @(posedge clk); @(negedge clk);
      tests++;
      if (instr_valid !== 1'b1 || instr !== w || pc !== m_pc ||
          instr_count !== m_cnt || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL backpressure got v=%b instr=%h pc=%h cnt=%0d req=%b want 1 %h %h %0d 0",
                 instr_valid, instr, pc, instr_count, imem_req, w, m_pc, m_cnt);
      end
    end
    instr_ready = 1; br_taken = taken; br_kind = kind;
    br_offset = off; br_reg_target = regt;
    m_cnt = m_cnt + 1;
    if (taken && kind == 2'b11) begin
      m_term = 1;
    end else begin
      t = model_target(m_pc, taken, kind, off, regt);
      m_pc = t;
      if (t[1:0] != 2'b00) m_term = 2;
    end
    @(posedge clk); @(negedge clk);
    instr_ready = 0; imem_rdy = 0;
    tests++;
    if (instr_count !== m_cnt || pc !== m_pc) begin
      fails++;
      $display("FAIL accept got cnt=%0d pc=%h want %0d %h",
               instr_count, pc, m_cnt, m_pc);
    end
    tests++;
    if (halted !== (m_term == 1) || fault !== (m_term == 2) ||
        imem_req !== (m_term == 0) || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL next_state got h=%b f=%b req=%b v=%b want h=%b f=%b req=%b v=0",
               halted, fault, imem_req, instr_valid,
               m_term == 1, m_term == 2, m_term == 0);
    end
  endtask

  task automatic test_reset();
    rst = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    tests++;
    if (imem_req !== 0 || pc !== 0 || instr !== 0 || instr_valid !== 0 ||
        halted !== 0 || fault !== 0 || instr_count !== 0 || imem_addr !== 0) begin
      fails++;
      $display("FAIL reset_vals got req=%b pc=%h instr=%h v=%b h=%b f=%b cnt=%0d want all 0",
               imem_req, pc, instr, instr_valid, halted, fault, instr_count);
    end
    rst = 1;
    @(posedge clk); @(negedge clk);
    tests++;
    if (imem_req !== 1 || imem_addr !== 0 || imem_addr2 !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL first_fetch got req=%b addr=%h addr2=%h want 1 0 fffffffc",
               imem_req, imem_addr, imem_addr2);
    end
    m_pc = 0; m_cnt = 0; m_term = 0;
  endtask

  task automatic test_sequential();
    exec_one(0, 0, 0, 2'b00, 0, 0);
    tests++;
    if (imem_req2 !== 1 || imem_addr2 !== 32'h0) begin
      fails++;
      $display("FAIL wrap got req=%b addr=%h want 1 00000000", imem_req2, imem_addr2);
    end
    exec_one(0, 0, 0, 2'b01, 23'h1, 0);
    exec_one(0, 0, 0, 2'b10, 0, 32'h2);
    tests++;
    if (instr_count !== 3 || imem_addr !== 32'hC) begin
      fails++;
      $display("FAIL seq3 got cnt=%0d addr=%h want 3 0000000c", instr_count, imem_addr);
    end
  endtask

  task automatic test_branch();
    exec_one(0, 0, 1, 2'b10, 0, 32'h40);
    exec_one(0, 0, 1, 2'b01, 23'h7F_FFFE, 0);
    tests++;
    if (imem_addr !== 32'h3C) begin
      fails++;
      $display("FAIL br_back got %h want 0000003c", imem_addr);
    end
    exec_one(0, 0, 1, 2'b10, 0, 32'h0);
    exec_one(0, 0, 1, 2'b01, 23'h3F_FFFF, 0);
    tests++;
    if (imem_addr !== 32'h0100_0000) begin
      fails++;
      $display("FAIL br_maxpos got %h want 01000000", imem_addr);
    end
    exec_one(0, 0, 1, 2'b10, 0, 32'h0);
    exec_one(0, 0, 1, 2'b01, 23'h40_0000, 0);
    tests++;
    if (imem_addr !== 32'hFF00_0004) begin
      fails++;
      $display("FAIL br_maxneg got %h want ff000004", imem_addr);
    end
  endtask

  task automatic test_jump_fault();
    logic [31:0] c;
    exec_one(3, 4, 1, 2'b10, 0, 32'h100);
    tests++;
    if (imem_addr !== 32'h100) begin
      fails++;
      $display("FAIL jump got %h want 00000100", imem_addr);
    end
    c = m_cnt;
    exec_one(0, 0, 1, 2'b10, 0, 32'h102);
    for (int i = 0; i < 3; i++) begin
      imem_rdy = 1; instr_ready = 1; br_taken = 1; br_kind = 2'b10;
      @(posedge clk); @(negedge clk);
      tests++;
      if (fault !== 1 || pc !== 32'h102 || imem_req !== 0 ||
          instr_count !== c + 1 || instr_valid !== 0) begin
        fails++;
        $display("FAIL fault_hold got f=%b pc=%h req=%b cnt=%0d v=%b want 1 00000102 0 %0d 0",
                 fault, pc, imem_req, instr_count, instr_valid, c + 1);
      end
    end
    imem_rdy = 0; instr_ready = 0;
  endtask

  task automatic test_halt();
    do_reset();
    exec_one(0, 0, 1, 2'b10, 0, 32'h20);
    exec_one(1, 1, 1, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) begin
      instr_ready = i[0]; imem_rdy = 1; br_taken = 1; br_kind = 2'b10;
      @(posedge clk); @(negedge clk);
      tests++;
      if (halted !== 1 || pc !== 32'h20 || instr_valid !== 0 ||
          imem_req !== 0 || instr_count !== 2) begin
        fails++;
        $display("FAIL halt_hold got h=%b pc=%h v=%b req=%b cnt=%0d want 1 00000020 0 0 2",
                 halted, pc, instr_valid, imem_req, instr_count);
      end
    end
    instr_ready = 0; imem_rdy = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tests++;
    if (halted !== 0 || fault !== 0 || imem_req !== 1 || imem_addr !== 0) begin
      fails++;
      $display("FAIL rst_from_halt got h=%b f=%b req=%b addr=%h want 0 0 1 0",
               halted, fault, imem_req, imem_addr);
    end
    exec_one(0, 0, 1, 2'b10, 0, 32'h80);
    imem_rdy = 0; rst = 0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (imem_req !== 0 || pc !== 0 || instr !== 0 || instr_valid !== 0 ||
        halted !== 0 || fault !== 0 || instr_count !== 0) begin
      fails++;
      $display("FAIL rst_mid got req=%b pc=%h instr=%h v=%b cnt=%0d want 0 0 0 0 0",
               imem_req, pc, instr, instr_valid, instr_count);
    end
    rst = 1;
    @(posedge clk); @(negedge clk);
    m_pc = 0; m_cnt = 0; m_term = 0;
    tests++;
    if (imem_req !== 1 || imem_addr !== 0) begin
      fails++;
      $display("FAIL rst_refetch got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic [31:0] rt;
    for (int n = 0; n < 80; n++) begin
      if (m_term != 0) do_reset();
      k  = 2'($urandom);
      if (k == 2'b11 && $urandom_range(0, 3) != 0) k = 2'b01;
      rt = $urandom;
      if ($urandom_range(0, 7) != 0) rt[1:0] = 2'b00;
      exec_one($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom),
               k, 23'($urandom), rt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_fault();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
